// File: rtl/fir_package.sv
// Shared types and constants for the FIR accelerator TCDM side.
package fir_package;

    localparam int FIR_TCDM_DW = 32;
    localparam int FIR_TCDM_BW = 4;

    // Fibonacci taps 16,14,13,11 in right-shift form (bits 0,2,3,5)
    localparam logic [15:0] FIR_TCDM_LFSR_TAPS = 16'h002D;

    typedef struct packed {
        logic [FIR_TCDM_DW-1:0] add;
        logic                   wen;
        logic [FIR_TCDM_BW-1:0] be;
        logic [FIR_TCDM_DW-1:0] data;
    } fir_tcdm_req_t;

    function automatic logic [15:0] fir_lfsr_step(input logic [15:0] s);
        return {^(s & FIR_TCDM_LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/hci_core_intf.sv
// HCI core TCDM port: request/grant plus one-cycle response channel.
interface hci_core_intf;
    import fir_package::*;

    logic                   req;
    logic                   gnt;
    logic [FIR_TCDM_DW-1:0] add;
    logic                   wen;
    logic [FIR_TCDM_BW-1:0] be;
    logic [FIR_TCDM_DW-1:0] data;
    logic [FIR_TCDM_DW-1:0] r_data;
    logic                   r_valid;

    modport initiator (
        output req, add, wen, be, data,
        input  gnt, r_data, r_valid
    );

    modport target (
        input  req, add, wen, be, data,
        output gnt, r_data, r_valid
    );

endinterface

// File: rtl/fir_tcdm_rr_arb.sv
// Round-robin arbiter: one-hot grant, pointer moves past the winner on advance.
module fir_tcdm_rr_arb
    import fir_package::*;
#(
    parameter int MP = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic [MP-1:0] req_i,
    input  logic          advance_i,
    output logic [MP-1:0] gnt_o
);

    localparam int PW = (MP > 1) ? $clog2(MP) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win;
    logic [PW-1:0] idx;
    int            idx_i;
    logic          found;

    always_comb begin
        gnt_o = '0;
        win   = '0;
        idx   = '0;
        idx_i = 0;
        found = 1'b0;
        for (int k = 0; k < MP; k++) begin
            idx_i = int'(ptr_q) + k;
            if (idx_i >= MP) idx_i = idx_i - MP;
            idx = PW'(idx_i);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        gnt_o[win] = found;

        ptr_d = ptr_q;
        if (clear_i) begin
            ptr_d = '0;
        end else if (advance_i && found) begin
            ptr_d = (int'(win) == MP - 1) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fir_tcdm_responder.sv
// Word-interleaved multi-bank TCDM target with per-bank RR arbitration
// and LFSR-driven global grant stalls.
module fir_tcdm_responder
    import fir_package::*;
#(
    parameter int          MP         = 3,
    parameter int          NB_BANKS   = 4,
    parameter int          BANK_WORDS = 1024,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter logic [3:0]  STALL_MASK = 4'b0011
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         stall_en_i,
    hci_core_intf.target tcdm [0:MP-1]
);

    localparam int BB = $clog2(NB_BANKS);
    localparam int RB = $clog2(BANK_WORDS);
    localparam int AB = 2 + BB + RB;

    fir_tcdm_req_t          preq [MP];
    logic [MP-1:0]          req;
    logic [BB-1:0]          bsel [MP];
    logic [RB-1:0]          row  [MP];
    logic [MP-1:0]          add_unused;
    logic [MP-1:0]          gnt;

    logic [MP-1:0]          r_valid_q, r_valid_d;
    logic [FIR_TCDM_DW-1:0] r_data_q [MP];
    logic [FIR_TCDM_DW-1:0] r_data_d [MP];

    logic [15:0]            lfsr_q, lfsr_d;
    logic                   stall;

    logic [MP-1:0]          bank_req [NB_BANKS];
    logic [MP-1:0]          bank_gnt [NB_BANKS];
    logic [FIR_TCDM_DW-1:0] bank_rd  [NB_BANKS];

    for (genvar p = 0; p < MP; p++) begin : g_port
        assign req[p]  = tcdm[p].req;
        assign preq[p] = '{
            add:  tcdm[p].add,
            wen:  tcdm[p].wen,
            be:   tcdm[p].be,
            data: tcdm[p].data
        };
        assign bsel[p] = preq[p].add[2 +: BB];
        assign row[p]  = preq[p].add[2 + BB +: RB];
        // upper bits wrap the address space; byte offset is ignored
        assign add_unused[p] = ^{preq[p].add[FIR_TCDM_DW-1:AB],
                                 preq[p].add[1:0]};

        assign tcdm[p].gnt     = gnt[p];
        assign tcdm[p].r_valid = r_valid_q[p];
        assign tcdm[p].r_data  = r_data_q[p];
    end

    assign stall = stall_en_i && ((lfsr_q[3:0] & STALL_MASK) == 4'b0000);

    always_comb begin
        lfsr_d = clear_i ? LFSR_SEED : fir_lfsr_step(lfsr_q);
    end

    for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
        logic [RB-1:0]          w_row;
        logic                   w_wen;
        logic [FIR_TCDM_BW-1:0] w_be;
        logic [FIR_TCDM_DW-1:0] w_data;
        logic                   w_we;
        logic [FIR_TCDM_DW-1:0] mem_q [BANK_WORDS];

        for (genvar p = 0; p < MP; p++) begin : g_req
            assign bank_req[b][p] = req[p] && (bsel[p] == BB'(b));
        end

        fir_tcdm_rr_arb #(
            .MP (MP)
        ) i_arb (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .clear_i   (clear_i),
            .req_i     (bank_req[b]),
            .advance_i (!stall),
            .gnt_o     (bank_gnt[b])
        );

        always_comb begin
            w_row  = '0;
            w_wen  = 1'b1;
            w_be   = '0;
            w_data = '0;
            for (int p = 0; p < MP; p++) begin
                if (bank_gnt[b][p]) begin
                    w_row  = row[p];
                    w_wen  = preq[p].wen;
                    w_be   = preq[p].be;
                    w_data = preq[p].data;
                end
            end
            w_we = !stall && !w_wen && (|bank_gnt[b]);
        end

        // contents survive reset and clear
        always_ff @(posedge clk_i) begin
            if (w_we) begin
                for (int i = 0; i < FIR_TCDM_BW; i++) begin
                    if (w_be[i]) mem_q[w_row][8*i +: 8] <= w_data[8*i +: 8];
                end
            end
        end

        assign bank_rd[b] = mem_q[w_row];
    end

    always_comb begin
        gnt = '0;
        for (int b = 0; b < NB_BANKS; b++) gnt = gnt | bank_gnt[b];
        if (stall) gnt = '0;
    end

    always_comb begin
        for (int p = 0; p < MP; p++) begin
            r_valid_d[p] = gnt[p];
            r_data_d[p]  = r_data_q[p];
            if (gnt[p]) r_data_d[p] = preq[p].wen ? bank_rd[bsel[p]] : '0;
            if (clear_i) begin
                r_valid_d[p] = 1'b0;
                r_data_d[p]  = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q    <= LFSR_SEED;
            r_valid_q <= '0;
            for (int p = 0; p < MP; p++) r_data_q[p] <= '0;
        end else begin
            lfsr_q    <= lfsr_d;
            r_valid_q <= r_valid_d;
            for (int p = 0; p < MP; p++) r_data_q[p] <= r_data_d[p];
        end
    end

endmodule

// File: tb/tb_fir_tcdm_responder.sv
// Directed bench for fir_tcdm_responder with hand-computed expectations.
module tb_fir_tcdm_responder;
    import fir_package::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        stall_en;

    logic [2:0]  req;
    logic [2:0]  wen;
    logic [31:0] add   [3];
    logic [3:0]  be    [3];
    logic [31:0] data  [3];
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [31:0] rdata [3];

    int n_cmp = 0;
    int n_err = 0;

    hci_core_intf tcdm_if [0:2] ();

    for (genvar g = 0; g < 3; g++) begin : g_port
        assign tcdm_if[g].req  = req[g];
        assign tcdm_if[g].wen  = wen[g];
        assign tcdm_if[g].add  = add[g];
        assign tcdm_if[g].be   = be[g];
        assign tcdm_if[g].data = data[g];
        assign gnt[g]    = tcdm_if[g].gnt;
        assign rvalid[g] = tcdm_if[g].r_valid;
        assign rdata[g]  = tcdm_if[g].r_data;
    end

    fir_tcdm_responder dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clear_i    (clear),
        .stall_en_i (stall_en),
        .tcdm       (tcdm_if)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic idle();
        req = '0;
        wen = '1;
        for (int i = 0; i < 3; i++) begin
            add[i]  = '0;
            be[i]   = '0;
            data[i] = '0;
        end
    endtask

    task automatic drive(input int p, input logic [31:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] d);
        req[p]  = 1'b1;
        add[p]  = a;
        wen[p]  = w;
        be[p]   = b;
        data[p] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one-cycle request on port p; returns gnt and next-cycle response
    task automatic access(input int p, input logic [31:0] a, input logic w,
                          input logic [3:0] b, input logic [31:0] d,
                          output logic g, output logic v,
                          output logic [31:0] rd);
        drive(p, a, w, b, d);
        #1;
        g = gnt[p];
        @(posedge clk);
        #1;
        v  = rvalid[p];
        rd = rdata[p];
        req[p] = 1'b0;
    endtask

    task automatic test_reset();
        for (int p = 0; p < 3; p++) begin
            n_cmp++;
            if (gnt[p] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_gnt[%0d]: got %b expected 0", p, gnt[p]);
            end
            n_cmp++;
            if (rvalid[p] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_rvalid[%0d]: got %b expected 0", p, rvalid[p]);
            end
            n_cmp++;
            if (rdata[p] !== 32'h0) begin
                n_err++;
                $display("FAIL reset_rdata[%0d]: got %h expected 0", p, rdata[p]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic g, v;
        logic [31:0] rd;
        access(0, 32'h10, 1'b0, 4'hF, 32'hDEADBEEF, g, v, rd);
        n_cmp++;
        if (g !== 1'b1) begin
            n_err++;
            $display("FAIL single_wr_gnt: got %b expected 1", g);
        end
        n_cmp++;
        if (v !== 1'b1 || rd !== 32'h0) begin
            n_err++;
            $display("FAIL single_wr_resp: got v=%b d=%h expected v=1 d=0", v, rd);
        end
        access(0, 32'h10, 1'b1, 4'hF, 32'h0, g, v, rd);
        n_cmp++;
        if (g !== 1'b1) begin
            n_err++;
            $display("FAIL single_rd_gnt: got %b expected 1", g);
        end
        n_cmp++;
        if (v !== 1'b1 || rd !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL single_rd_resp: got v=%b d=%h expected v=1 d=deadbeef", v, rd);
        end
        tick();
        n_cmp++;
        if (rvalid[0] !== 1'b0 || rdata[0] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL single_hold: got v=%b d=%h expected v=0 d=deadbeef",
                     rvalid[0], rdata[0]);
        end
        access(0, 32'h20, 1'b0, 4'hF, 32'hCAFEF00D, g, v, rd);
        n_cmp++;
        if (g !== 1'b1 || v !== 1'b1) begin
            n_err++;
            $display("FAIL single_wr2: got g=%b v=%b expected g=1 v=1", g, v);
        end
    endtask

    task automatic test_byte_en();
        logic g, v;
        logic [31:0] rd;
        access(0, 32'h0, 1'b0, 4'hF, 32'h11223344, g, v, rd);
        access(0, 32'h0, 1'b0, 4'b0101, 32'hAABBCCDD, g, v, rd);
        n_cmp++;
        if (g !== 1'b1) begin
            n_err++;
            $display("FAIL be_wr_gnt: got %b expected 1", g);
        end
        access(0, 32'h0, 1'b1, 4'hF, 32'h0, g, v, rd);
        n_cmp++;
        if (v !== 1'b1 || rd !== 32'h11BB33DD) begin
            n_err++;
            $display("FAIL be_rd: got v=%b d=%h expected v=1 d=11bb33dd", v, rd);
        end
    endtask

    task automatic test_parallel();
        logic [31:0] exp_d [3];
        exp_d[0] = 32'h0000AAAA;
        exp_d[1] = 32'h1111BBBB;
        exp_d[2] = 32'h2222CCCC;
        drive(0, 32'h30, 1'b0, 4'hF, exp_d[0]);
        drive(1, 32'h34, 1'b0, 4'hF, exp_d[1]);
        drive(2, 32'h38, 1'b0, 4'hF, exp_d[2]);
        #1;
        n_cmp++;
        if (gnt !== 3'b111) begin
            n_err++;
            $display("FAIL par_wr_gnt: got %b expected 111", gnt);
        end
        tick();
        n_cmp++;
        if (rvalid !== 3'b111) begin
            n_err++;
            $display("FAIL par_wr_rvalid: got %b expected 111", rvalid);
        end
        for (int p = 0; p < 3; p++) wen[p] = 1'b1;
        #1;
        n_cmp++;
        if (gnt !== 3'b111) begin
            n_err++;
            $display("FAIL par_rd_gnt: got %b expected 111", gnt);
        end
        tick();
        req = '0;
        n_cmp++;
        if (rvalid !== 3'b111) begin
            n_err++;
            $display("FAIL par_rd_rvalid: got %b expected 111", rvalid);
        end
        for (int p = 0; p < 3; p++) begin
            n_cmp++;
            if (rdata[p] !== exp_d[p]) begin
                n_err++;
                $display("FAIL par_rd_data[%0d]: got %h expected %h", p, rdata[p], exp_d[p]);
            end
        end
    endtask

    task automatic test_conflict();
        logic [31:0] exp_d [3];
        logic [2:0]  eg;
        exp_d[0] = 32'h11BB33DD;
        exp_d[1] = 32'hDEADBEEF;
        exp_d[2] = 32'hCAFEF00D;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        drive(0, 32'h00, 1'b1, 4'hF, 32'h0);
        drive(1, 32'h10, 1'b1, 4'hF, 32'h0);
        drive(2, 32'h20, 1'b1, 4'hF, 32'h0);
        for (int k = 0; k < 4; k++) begin
            eg = (k == 0) ? 3'b001 : (k == 1) ? 3'b010 : (k == 2) ? 3'b100 : 3'b000;
            #1;
            n_cmp++;
            if (gnt !== eg) begin
                n_err++;
                $display("FAIL conf_gnt[%0d]: got %b expected %b", k, gnt, eg);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (rvalid !== eg) begin
                n_err++;
                $display("FAIL conf_rvalid[%0d]: got %b expected %b", k, rvalid, eg);
            end
            for (int p = 0; p < 3; p++) begin
                if (eg[p]) begin
                    n_cmp++;
                    if (rdata[p] !== exp_d[p]) begin
                        n_err++;
                        $display("FAIL conf_data[%0d]: got %h expected %h", p, rdata[p], exp_d[p]);
                    end
                end
            end
            req = req & ~eg;
        end
    endtask

    task automatic test_stall();
        logic [15:0] m;
        logic        g, exp_g;
        int den_dut, den_ref, bad_g, bad_v, bad_d;
        den_dut = 0;
        den_ref = 0;
        bad_g   = 0;
        bad_v   = 0;
        bad_d   = 0;
        clear = 1'b1;
        tick();
        clear    = 1'b0;
        stall_en = 1'b1;
        m        = 16'hACE1;
        drive(0, 32'h10, 1'b1, 4'hF, 32'h0);
        for (int c = 0; c < 1000; c++) begin
            #1;
            g     = gnt[0];
            exp_g = (m[1:0] != 2'b00);
            if (!g) den_dut++;
            if (!exp_g) den_ref++;
            if (g !== exp_g) bad_g++;
            @(posedge clk);
            #1;
            if (rvalid[0] !== g) bad_v++;
            if (g && rdata[0] !== 32'hDEADBEEF) bad_d++;
            m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
        end
        req      = '0;
        stall_en = 1'b0;
        n_cmp++;
        if (den_dut != den_ref) begin
            n_err++;
            $display("FAIL stall_denied: got %0d expected %0d", den_dut, den_ref);
        end
        n_cmp++;
        if (bad_g != 0) begin
            n_err++;
            $display("FAIL stall_gnt_pattern: got %0d bad cycles expected 0", bad_g);
        end
        n_cmp++;
        if (bad_v != 0) begin
            n_err++;
            $display("FAIL stall_rvalid: got %0d bad cycles expected 0", bad_v);
        end
        n_cmp++;
        if (bad_d != 0) begin
            n_err++;
            $display("FAIL stall_rdata: got %0d bad cycles expected 0", bad_d);
        end
    endtask

    task automatic test_wrap();
        logic g, v;
        logic [31:0] rd;
        access(0, 32'h4000, 1'b1, 4'hF, 32'h0, g, v, rd);
        n_cmp++;
        if (g !== 1'b1 || v !== 1'b1 || rd !== 32'h11BB33DD) begin
            n_err++;
            $display("FAIL wrap_rd: got g=%b v=%b d=%h expected g=1 v=1 d=11bb33dd",
                     g, v, rd);
        end
    endtask

    task automatic test_reset_mid();
        logic g, v;
        logic [31:0] rd;
        drive(1, 32'h0, 1'b1, 4'hF, 32'h0);
        #1;
        n_cmp++;
        if (gnt[1] !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_gnt: got %b expected 1", gnt[1]);
        end
        #1;
        rst_n  = 1'b0;
        req[1] = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (rvalid[1] !== 1'b0 || rdata[1] !== 32'h0) begin
            n_err++;
            $display("FAIL rst_mid_rvalid: got v=%b d=%h expected v=0 d=0",
                     rvalid[1], rdata[1]);
        end
        rst_n = 1'b1;
        tick();
        access(1, 32'h0, 1'b1, 4'hF, 32'h0, g, v, rd);
        n_cmp++;
        if (v !== 1'b1 || rd !== 32'h11BB33DD) begin
            n_err++;
            $display("FAIL rst_mem_kept: got v=%b d=%h expected v=1 d=11bb33dd", v, rd);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        clear    = 1'b0;
        stall_en = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        tick();
        test_single();
        test_byte_en();
        test_parallel();
        test_conflict();
        test_stall();
        tick();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
